// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder and its controller.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-clock word RAM: one write port (preload has priority over the bus) and one registered read port.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              bus_we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wd;

    always_comb begin
        we    = ld_en | bus_we;
        waddr = ld_en ? ld_addr : bus_addr;
        wd    = ld_en ? ld_data : bus_data;
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wd;
    end

    // Only the read register is reset; storage keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (reset)
            rdata <= '0;
        else if (rd_en)
            rdata <= mem[bus_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a read/write request, waits LATENCY cycles, then
// raises MFC and holds it until the initiator drops its strobe.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    op_t                op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic strobe_held;
    logic fire;
    logic accept;
    logic mfc_next;
    logic err_next;
    logic bus_we;
    logic rd_en;

    // Upper MAR bits alias onto the decoded range.
    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            MFC   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            MFC   <= mfc_next;
            err   <= err_next;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            op_q    <= write ? OP_WRITE : OP_READ;
        end
    end

    always_comb begin
        strobe_held = (op_q == OP_WRITE) ? write : read;
        state_next  = state;
        cnt_next    = cnt;
        unique case (state)
            IDLE: begin
                if (read ^ write) begin
                    state_next = WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                if (!strobe_held)
                    state_next = IDLE;
                else if (cnt == '0)
                    state_next = DONE;
                else
                    cnt_next = cnt - 1'b1;
            end
            DONE: begin
                if (!read && !write)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Commit strobes are gated by reset so a reset landing on the final WAIT cycle cancels the write.
    always_comb begin
        fire     = (state == WAIT) && strobe_held && (cnt == '0);
        accept   = (state == IDLE) && (read ^ write);
        err_next = (state == IDLE) && read && write;
        bus_we   = fire && (op_q == OP_WRITE) && !reset;
        rd_en    = fire && (op_q == OP_READ) && !reset;
        mfc_next = MFC;
        unique case (state)
            IDLE: mfc_next = 1'b0;
            WAIT: mfc_next = fire;
            DONE: if (!read && !write) mfc_next = 1'b0;
            default: mfc_next = 1'b0;
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .bus_we   (bus_we),
        .rd_en    (rd_en),
        .bus_addr (addr_q),
        .bus_data (wdata_q),
        .rdata    (rdata)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU controller's asynchronous-style memory handshake. It accepts `read` and `write` strobes with an address from MAR and write data from MDR. After a programmable access latency it asserts `MFC` (memory function complete), drives read data, and holds `MFC` until the initiator drops its strobe. It sits between the controller/datapath and a word-addressed RAM. A side-band load port lets the bench preload program words (instructions) before or between accesses.

## Interface
- `ADDR_W`, 8: number of address bits decoded; depth = 2**ADDR_W words.
- `DATA_W`, 16: word width; matches IR/MDR width.
- `LATENCY`, 2: number of WAIT cycles before `MFC`; legal range 1..15.

- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `read`  in  1  read strobe from controller (level, held until MFC seen).
- `write`  in  1  write strobe from controller (level, held until MFC seen).
- `addr`  in  16  address from MAR; only `addr[ADDR_W-1:0]` decoded, upper bits ignored (aliasing).
- `wdata`  in  DATA_W  write data from MDR.
- `rdata`  out  DATA_W  read data toward MDR/data bus; valid while `MFC`=1 after a read.
- `MFC`  out  1  memory function complete.
- `err`  out  1  one-cycle pulse: `read` and `write` both high while IDLE.
- `ld_en`  in  1  preload write enable.
- `ld_addr`  in  ADDR_W  preload address.
- `ld_data`  in  DATA_W  preload data.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - Exactly one of `read`/`write` high at an edge: latch `addr`, `wdata` and op; set `cnt <= LATENCY-1`; go to WAIT.
  - Both high: pulse `err`, latch nothing, stay in IDLE.
- **WAIT**
  - Priority 1, abort: the latched op's strobe is low at an edge. Go to IDLE with no memory update and no `MFC`.
  - Priority 2, `cnt == 0`:
    - Read: `rdata <= mem[latched addr]`.
    - Write: `mem[latched addr] <= latched wdata`; `rdata` unchanged.
    - In both cases `MFC <= 1` and go to DONE.
  - Otherwise: `cnt <= cnt-1`.
- **DONE**
  - `MFC` and `rdata` hold.
  - `read`=0 and `write`=0 at an edge: `MFC <= 0`, go to IDLE.
  - A strobe still high (including one switched to the other op): stay in DONE. Each access completes one full four-phase handshake.
- **Addresses and data**
  - Latched address is used throughout; `addr`/`wdata` changes after acceptance are ignored.
  - No arithmetic beyond `cnt` decrement. `cnt` is 4 bits.
- **Preload port**
  - `ld_en` writes `mem[ld_addr] <= ld_data` in any state.
  - If a bus write commits to the same address in the same cycle, the preload wins.
- **Reset**
  - State goes to IDLE; `MFC`=0, `err`=0, `rdata`=0, `cnt`=0.
  - Memory contents are NOT cleared.
  - Reset mid-WAIT cancels the access (no write commit).

## Timing
- Request first sampled high at edge k: `MFC` rises after edge k+LATENCY. Read data is valid in the same cycle.
- Strobe low sampled at edge j in DONE: `MFC` falls after edge j.
- The next request can be accepted no earlier than edge j+1.
- Minimum handshake is LATENCY+2 edges, request-accept to IDLE.
- `err` is high for exactly the cycle after the offending edge.
- Read is registered from the array: no combinational path from `addr` to `rdata`.
- `MFC` is a registered output.

## Structure
- Package `mem_pkg`:
  - state enum (IDLE/WAIT/DONE);
  - op constants (OP_READ/OP_WRITE);
  - default `DATA_W`/`ADDR_W` localparams, shared with the controller.
- One sub-module, `mem_array`: single-clock RAM.
  - One write port, muxed between preload and bus with preload priority.
  - One registered read port.
  - No reset on storage.

## Test plan
- Preload `mem[3]=16'hF240`, `LATENCY=2`. Hold `read`=1, `addr=16'h0003` from edge 0. Expect `MFC`=1 and `rdata=16'hF240` after edge 2. Drop `read` at edge 4; expect `MFC`=0 after edge 4.
- Write `16'hBEEF` to `addr=16'h0105` (aliases to word 5 with `ADDR_W`=8), then read `addr=16'h0005`. Expect `rdata=16'hBEEF`.
- Assert `read` and `write` together in IDLE. Expect a one-cycle `err` pulse, no `MFC`, memory unchanged.
- Start a write of `16'h1234` to word 7 and drop `write` after one WAIT cycle (`LATENCY=3`). Expect no `MFC`, `mem[7]` keeps its old value, and a new read is accepted the next edge.
- Keep `read` high for 5 cycles after `MFC`. Expect `MFC` to stay high with `rdata` stable and no second access. Then assert `reset` during a subsequent WAIT; expect `MFC`=0, `rdata`=0, and the target word not overwritten.
- In the same cycle, apply `ld_en` with `ld_addr=9`, `ld_data=16'hAAAA`, and a bus write commit of `16'h5555` to word 9. Expect a later read of word 9 to return `16'hAAAA`.
